// File: rtl/piso_pkg.sv
// Shared types and width helpers for the parallel-in serial-out shifter.
package piso_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } piso_state_e;

    // Bit-counter width for a word of the given size; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that saturates at zero; tracks the bits left in a word.
module piso_bit_counter #(
    parameter int unsigned Width   = 5,
    parameter int unsigned LoadVal = 31
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [Width-1:0] LoadCnt = Width'(LoadVal);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadCnt;
        end else if (en && !zero) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: accepts a word on a ready/valid handshake
// and emits it MSB first on q, pausing whenever en is low.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int unsigned MSB = 32
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [MSB-1:0] data,
    output logic           q,
    output logic           q_valid,
    output logic           done
);

    localparam int unsigned CntW = cnt_width(MSB);

    piso_state_e    state_q, state_d;
    logic [MSB-1:0] shreg_q, shreg_d;
    logic           done_q, done_d;
    logic           accept;
    logic           cnt_en;
    logic           cnt_zero;

    assign load_ready = (state_q == StIdle);
    assign accept     = load_ready && load_valid;
    assign cnt_en     = (state_q == StShift) && en;
    assign q_valid    = (state_q == StShift);
    assign q          = (state_q == StShift) ? shreg_q[MSB-1] : 1'b0;
    assign done       = done_q;

    piso_bit_counter #(
        .Width   (CntW),
        .LoadVal (MSB - 1)
    ) u_bit_counter (
        .clk  (clk),
        .rstn (rstn),
        .load (accept),
        .en   (cnt_en),
        .zero (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    shreg_d = data;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (en) begin
                    // Counter at zero means the last bit is on q right now.
                    if (cnt_zero) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[MSB-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed and loopback checks for piso_shift_reg with an 8-bit word.
module tb_piso_shift_reg;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] data = '0;
    logic         q;
    logic         q_valid;
    logic         done;

    int checks = 0;
    int errors = 0;

    piso_shift_reg #(
        .MSB (W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data       (data),
        .q          (q),
        .q_valid    (q_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Serial-in receiver for the loopback test.
    logic [W-1:0] sipo = '0;
    always @(posedge clk) begin
        if (q_valid && en) sipo <= {sipo[W-2:0], q};
    end

    // Inputs applied for one edge, then expected {q, q_valid, done, load_ready} after it.
    typedef struct {
        logic         rstn;
        logic         en;
        logic         lv;
        logic [W-1:0] data;
        logic [3:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic r, input logic e, input logic lv, input logic [W-1:0] d,
                        input logic [3:0] exp);
        vec_t v;
        v.rstn = r; v.en = e; v.lv = lv; v.data = d; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] w1, w2, word;
        logic         seen_done, got;

        // Basic word 0xA5 = 1010_0101
        push(0, 1, 0, 8'h00, 4'b0001);
        push(1, 1, 1, 8'hA5, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0011);
        push(1, 1, 0, 8'h00, 4'b0001);
        // Enable gaps with 0xC3 = 1100_0011: alternate hold / shift
        push(1, 1, 1, 8'hC3, 4'b1100);
        push(1, 0, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 0, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 0, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 0, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 0, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 0, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 0, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 0, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0011);
        push(1, 0, 0, 8'h00, 4'b0001);
        // Ignored load: 0xF0 in flight while 0x0F is offered
        push(1, 1, 1, 8'hF0, 4'b1100);
        push(1, 1, 1, 8'h0F, 4'b1100);
        push(1, 1, 1, 8'h0F, 4'b1100);
        push(1, 1, 1, 8'h0F, 4'b1100);
        push(1, 1, 1, 8'h0F, 4'b0100);
        push(1, 1, 1, 8'h0F, 4'b0100);
        push(1, 1, 1, 8'h0F, 4'b0100);
        push(1, 1, 1, 8'h0F, 4'b0100);
        push(1, 1, 1, 8'h0F, 4'b0011);
        push(1, 1, 1, 8'h0F, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b0100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b1100);
        push(1, 1, 0, 8'h00, 4'b0011);
        push(1, 1, 0, 8'h00, 4'b0001);

        #1;
        foreach (vecs[i]) begin
            rstn = vecs[i].rstn;
            en = vecs[i].en;
            load_valid = vecs[i].lv;
            data = vecs[i].data;
            step();
            check($sformatf("vec%0d", i), {4'b0, q, q_valid, done, load_ready},
                  {4'b0, vecs[i].exp});
        end

        // Back-to-back 0x81 then 0x7E with load_valid held high
        w1 = 8'h81;
        w2 = 8'h7E;
        en = 1'b1;
        load_valid = 1'b1;
        data = w1;
        step();
        data = w2;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_w1_bit%0d", i), {6'b0, q, q_valid}, {6'b0, w1[7-i], 1'b1});
            step();
        end
        check("b2b_done1", {5'b0, q_valid, done, load_ready}, 8'b0000_0011);
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_w2_bit%0d", i), {6'b0, q, q_valid}, {6'b0, w2[7-i], 1'b1});
            step();
        end
        check("b2b_done2", {5'b0, q_valid, done, load_ready}, 8'b0000_0011);

        // Reset mid-word: 0xFF aborted after three bits
        load_valid = 1'b1;
        data = 8'hFF;
        step();
        load_valid = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_bit%0d", i), {6'b0, q, q_valid}, 8'b0000_0011);
            if (i < 2) step();
        end
        rstn = 1'b0;
        step();
        check("rst_outputs", {4'b0, q, q_valid, done, load_ready}, 8'b0000_0001);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        check("rst_no_done", {7'b0, seen_done}, 8'h00);

        // Loopback with random words and random enable
        for (int n = 0; n < 100; n++) begin
            word = W'($urandom);
            en = 1'($urandom_range(0, 1));
            load_valid = 1'b1;
            data = word;
            step();
            load_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 64 && !got; c++) begin
                en = 1'($urandom_range(0, 1));
                step();
                if (done) begin
                    got = 1'b1;
                    check($sformatf("loop_word%0d", n), sipo, word);
                end
            end
            check($sformatf("loop_done%0d", n), {7'b0, got}, 8'h01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
